xs3_to_bcd_stream: RTL



---
 rtl/xs3_pkg.sv | 10 +
 rtl/xs3_digit_decode.sv | 19 +
 rtl/xs3_to_bcd_stream.sv | 98 +++++++++
 3 files changed

// File: rtl/xs3_pkg.sv
// Shared constants and FSM state type for the excess-3 to BCD stream decoder.
package xs3_pkg;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'h3;
   localparam logic [3:0] XS3_MAX    = 4'hC;

   typedef enum logic {COLLECT, HOLD} xs3_state_t;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational excess-3 digit decode. With XS3_ERR_CHECK_EN defined, out-of-range
// codes decode to 0 and raise bad; otherwise the offset is removed modulo 16.
module xs3_digit_decode
   import xs3_pkg::*;
(
   input  logic [3:0] in_xs3,
   output logic [3:0] dig,
   output logic       bad
);

`ifdef XS3_ERR_CHECK_EN
   assign bad = (in_xs3 < XS3_MIN) || (in_xs3 > XS3_MAX);
   assign dig = bad ? 4'h0 : (in_xs3 - XS3_OFFSET);
`else
   assign bad = 1'b0;
   assign dig = in_xs3 - XS3_OFFSET;
`endif

endmodule

// File: rtl/xs3_to_bcd_stream.sv
// Streaming excess-3 to packed-BCD decoder: collects up to NDIG digits (MSD first)
// and presents each word on a valid/ready output. Optional range check: XS3_ERR_CHECK_EN.
module xs3_to_bcd_stream
   import xs3_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int CW   = $clog2(NDIG + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_xs3,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NDIG-1:0] out_bcd,
   output logic [CW-1:0]     out_count,
   output logic              out_err
);

   xs3_state_t        state, state_nxt;
   logic [4*NDIG-1:0] acc, acc_shift;
   logic [CW-1:0]     cnt;
   logic [3:0]        dig;
   logic              bad;
   logic              accept, close, xfer;

   xs3_digit_decode u_dec (
      .in_xs3 (in_xs3),
      .dig    (dig),
      .bad    (bad)
   );

   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   assign acc_shift = (acc << 4) | (4*NDIG)'(dig);
   // The NDIG-th digit closes the word even without in_last.
   assign close     = accept & (in_last | (cnt == CW'(NDIG - 1)));

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (close)     state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = COLLECT;
         default:                state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (xfer) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= acc_shift;
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_bcd   <= '0;
         out_count <= '0;
      end else if (close) begin
         out_bcd   <= acc_shift;
         out_count <= cnt + CW'(1);
      end
   end

`ifdef XS3_ERR_CHECK_EN
   logic err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err     <= 1'b0;
         out_err <= 1'b0;
      end else begin
         if (xfer)        err <= 1'b0;
         else if (accept) err <= err | bad;
         if (close)       out_err <= err | bad;
      end
   end
`else
   // bad is constant 0 in this build, so this is a tie-off with no flop.
   assign out_err = bad;
`endif

endmodule
